// File: rtl/stdout_uart_pkg.sv
// Shared types and width helpers for the stdout UART transmitter.
package stdout_uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy must represent 0..depth inclusive, hence one extra bit.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int baud_width(input int clks);
        return (clks > 1) ? $clog2(clks) : 1;
    endfunction

endpackage

// File: rtl/stdout_fifo.sv
// Byte FIFO between the core's stdout writes and the UART serialiser.
module stdout_fifo
    import stdout_uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_W     = UART_DATA_BITS
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                push,
    input  logic [DATA_W-1:0]                   push_data,
    input  logic                                pop,
    output logic [DATA_W-1:0]                   pop_data,
    output logic [count_width(FIFO_DEPTH)-1:0]  count,
    output logic                                full,
    output logic                                empty
);

    localparam int PTR_W = ptr_width(FIFO_DEPTH);
    localparam int CNT_W = count_width(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              push_ok;
    logic              pop_ok;

    // A push while full is dropped even if a pop frees a slot this same cycle.
    assign full     = (count_reg == CNT_W'(FIFO_DEPTH));
    assign empty    = (count_reg == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign count    = count_reg;
    // Head is visible combinationally so the serialiser can load it on the pop edge.
    assign pop_data = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/stdout_uart_tx.sv
// stdout sink: buffers bytes from the core and sends them as 8N1 frames on txd.
module stdout_uart_tx
    import stdout_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                stdout_write_enable,
    input  logic [7:0]                          stdout_data,
    output logic                                stdout_full,
    output logic                                txd,
    output logic                                tx_busy,
    output logic [count_width(FIFO_DEPTH)-1:0]  fifo_count,
    output logic                                overflow
);

    localparam int BAUD_W = baud_width(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(UART_DATA_BITS);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(UART_DATA_BITS - 1);

    tx_state_t         state_reg, state_next;
    logic [BAUD_W-1:0] baud_reg, baud_next;
    logic [BIT_W-1:0]  bit_reg, bit_next;
    logic [7:0]        shift_reg, shift_next;
    logic              txd_reg, txd_next;
    logic              overflow_reg, overflow_next;
    logic              fifo_pop;
    logic              fifo_empty;
    logic              fifo_full;
    logic [7:0]        fifo_head;
    logic              baud_done;

    stdout_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DATA_W     (8)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (stdout_write_enable),
        .push_data (stdout_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign baud_done     = (baud_reg == BAUD_LAST);
    assign overflow_next = overflow_reg | (stdout_write_enable & fifo_full);

    always_comb begin
        state_next = state_reg;
        baud_next  = baud_reg + 1'b1;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        txd_next   = txd_reg;
        fifo_pop   = 1'b0;
        case (state_reg)
            IDLE: begin
                baud_next = '0;
                txd_next  = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shift_next = fifo_head;
                    txd_next   = 1'b0;
                    state_next = START;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_next  = '0;
                    bit_next   = '0;
                    txd_next   = shift_reg[0];
                    state_next = DATA;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_next = '0;
                    if (bit_reg == BIT_LAST) begin
                        txd_next   = 1'b1;
                        state_next = STOP;
                    end else begin
                        bit_next   = bit_reg + 1'b1;
                        shift_next = shift_reg >> 1;
                        txd_next   = shift_reg[1];
                    end
                end
            end
            STOP: begin
                // Chain straight into the next start bit so queued frames abut.
                if (baud_done) begin
                    baud_next = '0;
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        shift_next = fifo_head;
                        txd_next   = 1'b0;
                        state_next = START;
                    end else begin
                        txd_next   = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                txd_next   = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            baud_reg     <= '0;
            bit_reg      <= '0;
            shift_reg    <= '0;
            txd_reg      <= 1'b1;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            baud_reg     <= baud_next;
            bit_reg      <= bit_next;
            shift_reg    <= shift_next;
            txd_reg      <= txd_next;
            overflow_reg <= overflow_next;
        end
    end

    assign txd         = txd_reg;
    assign stdout_full = fifo_full;
    assign tx_busy     = (state_reg != IDLE) || !fifo_empty;
    assign overflow    = overflow_reg;

endmodule

// File: tb/tb_stdout_uart_tx.sv
// Directed and randomized checks of stdout_uart_tx against a frame-level line model.
module tb_stdout_uart_tx;

    localparam int C     = 4;
    localparam int C2    = 2;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       we, we2;
    logic [7:0] data, data2;
    logic       full, txd, busy, ovf;
    logic       full2, txd2, busy2, ovf2;
    logic [4:0] count, count2;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] rx_q[$];
    int         start_q[$];
    logic [7:0] exp_q[$];
    int         cyc       = 0;
    int         mon_phase = -1;
    int         mon_start = 0;
    logic [7:0] mon_byte  = 8'h00;

    always #5 clk = ~clk;

    stdout_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .stdout_write_enable(we), .stdout_data(data),
        .stdout_full(full), .txd(txd), .tx_busy(busy), .fifo_count(count), .overflow(ovf)
    );

    stdout_uart_tx #(.CLKS_PER_BIT(C2), .FIFO_DEPTH(DEPTH)) dut2 (
        .clk(clk), .rst(rst), .stdout_write_enable(we2), .stdout_data(data2),
        .stdout_full(full2), .txd(txd2), .tx_busy(busy2), .fifo_count(count2), .overflow(ovf2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Line level of frame bit k (0=start, 1..8=data LSB first, 9=stop).
    function automatic logic fbit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        return 1'b1;
    endfunction

    // Independent UART receiver sampling mid-bit on the dut line.
    always @(negedge clk) begin
        cyc++;
        if (rst === 1'b1) begin
            mon_phase = -1;
        end else if (mon_phase < 0) begin
            if (txd === 1'b0) begin
                mon_phase = 0;
                mon_start = cyc;
            end
        end else begin
            mon_phase++;
            if ((mon_phase % C) == (C / 2)) begin
                if (mon_phase / C >= 1 && mon_phase / C <= 8) begin
                    mon_byte[mon_phase / C - 1] = txd;
                end else if (mon_phase / C == 9) begin
                    check("stop_bit", {31'b0, txd}, 32'h1);
                    rx_q.push_back(mon_byte);
                    start_q.push_back(mon_start);
                    $display("rx byte %02h start cycle %0d", mon_byte, mon_start);
                    mon_phase = -1;
                end
            end
        end
    end

    task automatic compare_rx(input string tag, input bit contiguous);
        check({tag, "_rx_len"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            check({tag, "_rx_byte"}, {24'b0, rx_q[i]}, {24'b0, exp_q[i]});
            if (contiguous && i > 0) begin
                check({tag, "_gap"}, start_q[i] - start_q[i-1], 10 * C);
            end
        end
        rx_q.delete();
        start_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_idle_timeout"}, {31'b0, busy}, 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int         n;
        logic [7:0] b;
        logic [7:0] burst [17];

        rst = 1'b1; we = 1'b0; we2 = 1'b0; data = 8'h00; data2 = 8'h00;
        repeat (2) tick();
        check("rst_txd", {31'b0, txd}, 32'h1);
        check("rst_full", {31'b0, full}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_count", {27'b0, count}, 32'h0);
        check("rst_ovf", {31'b0, ovf}, 32'h0);
        rst = 1'b0;
        tick();

        // Single 0x55 frame, exact per-cycle waveform.
        we = 1'b1; data = 8'h55; tick(); we = 1'b0;
        check("t1_count_push", {27'b0, count}, 32'h1);
        check("t1_txd_idle", {31'b0, txd}, 32'h1);
        for (int i = 0; i < 10 * C; i++) begin
            tick();
            check("t1_txd", {31'b0, txd}, {31'b0, fbit(8'h55, i / C)});
            check("t1_busy", {31'b0, busy}, 32'h1);
            if (i == 0) check("t1_count_pop", {27'b0, count}, 32'h0);
        end
        tick();
        check("t1_txd_end", {31'b0, txd}, 32'h1);
        check("t1_busy_end", {31'b0, busy}, 32'h0);
        exp_q.push_back(8'h55);
        compare_rx("t1", 1'b0);

        // Two back-to-back frames.
        we = 1'b1; data = 8'hA3; tick();
        check("t2_count0", {27'b0, count}, 32'h1);
        data = 8'h0F; tick(); we = 1'b0;
        check("t2_count1", {27'b0, count}, 32'h1);
        check("t2_txd", {31'b0, txd}, 32'h0);
        for (int i = 1; i < 20 * C; i++) begin
            tick();
            b = (i < 10 * C) ? 8'hA3 : 8'h0F;
            check("t2_txd", {31'b0, txd}, {31'b0, fbit(b, (i % (10 * C)) / C)});
            if (i == 10 * C - 1) check("t2_count_hold", {27'b0, count}, 32'h1);
            if (i == 10 * C) check("t2_count_pop", {27'b0, count}, 32'h0);
        end
        tick();
        check("t2_busy_end", {31'b0, busy}, 32'h0);
        exp_q.push_back(8'hA3);
        exp_q.push_back(8'h0F);
        compare_rx("t2", 1'b1);

        // Short bit period on the second instance.
        we2 = 1'b1; data2 = 8'h80; tick(); we2 = 1'b0;
        check("t6_count", {27'b0, count2}, 32'h1);
        for (int i = 0; i < 10 * C2; i++) begin
            tick();
            check("t6_txd", {31'b0, txd2}, {31'b0, fbit(8'h80, i / C2)});
            check("t6_busy", {31'b0, busy2}, 32'h1);
        end
        tick();
        check("t6_txd_end", {31'b0, txd2}, 32'h1);
        check("t6_busy_end", {31'b0, busy2}, 32'h0);
        check("t6_full", {31'b0, full2}, 32'h0);
        check("t6_ovf", {31'b0, ovf2}, 32'h0);

        // Fill the FIFO while a lead frame is on the line, overflow, then drop at the pop edge.
        for (int k = 0; k < 17; k++) burst[k] = 8'($urandom);
        we = 1'b1; data = 8'hC6; tick(); we = 1'b0;
        repeat (4) tick();
        for (int k = 0; k < 17; k++) begin
            if (k == 16) begin
                check("t3_full_before", {31'b0, full}, 32'h1);
                check("t3_ovf_before", {31'b0, ovf}, 32'h0);
            end
            we = 1'b1; data = burst[k]; tick();
            check("t3_count", {27'b0, count}, (k < 16) ? k + 1 : 16);
        end
        we = 1'b0;
        check("t3_full", {31'b0, full}, 32'h1);
        check("t3_ovf", {31'b0, ovf}, 32'h1);
        repeat (19) tick();
        check("t4_stop_txd", {31'b0, txd}, 32'h1);
        check("t4_count_full", {27'b0, count}, DEPTH);
        we = 1'b1; data = 8'hEE; tick(); we = 1'b0;
        check("t4_count_pop", {27'b0, count}, DEPTH - 1);
        check("t4_full_clear", {31'b0, full}, 32'h0);
        check("t4_start_txd", {31'b0, txd}, 32'h0);
        wait_idle("t3", 1000);
        exp_q.push_back(8'hC6);
        for (int k = 0; k < 16; k++) exp_q.push_back(burst[k]);
        compare_rx("t3", 1'b1);

        // Random bytes at random spacing; never enough in flight to fill the FIFO.
        n = $urandom_range(3, 8);
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 30)) tick();
            b = 8'($urandom);
            we = 1'b1; data = b; tick(); we = 1'b0;
            exp_q.push_back(b);
        end
        wait_idle("rand", 1000);
        compare_rx("rand", 1'b0);
        check("rand_ovf_sticky", {31'b0, ovf}, 32'h1);

        // Reset in the middle of a data bit of 0xFF.
        we = 1'b1; data = 8'hFF; tick();
        data = 8'h3C; tick(); we = 1'b0;
        repeat (10) tick();
        check("t5a_txd_data", {31'b0, txd}, 32'h1);
        check("t5a_count", {27'b0, count}, 32'h1);
        #3 rst = 1'b1;
        #1;
        check("t5a_txd", {31'b0, txd}, 32'h1);
        check("t5a_count_rst", {27'b0, count}, 32'h0);
        check("t5a_ovf_rst", {31'b0, ovf}, 32'h0);
        check("t5a_busy_rst", {31'b0, busy}, 32'h0);
        tick(); tick();
        rst = 1'b0;

        // Reset during a start bit: txd must rise without waiting for a clock edge.
        we = 1'b1; data = 8'h12; tick();
        data = 8'h34; tick(); we = 1'b0;
        tick();
        check("t5b_txd_start", {31'b0, txd}, 32'h0);
        check("t5b_count", {27'b0, count}, 32'h1);
        #3 rst = 1'b1;
        #1;
        check("t5b_txd", {31'b0, txd}, 32'h1);
        check("t5b_count_rst", {27'b0, count}, 32'h0);
        check("t5b_busy_rst", {31'b0, busy}, 32'h0);
        check("t5b_full_rst", {31'b0, full}, 32'h0);
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            check("t5_quiet_txd", {31'b0, txd}, 32'h1);
            check("t5_quiet_busy", {31'b0, busy}, 32'h0);
        end
        check("t5_no_residual", rx_q.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
